bank_queue_scheduler: RTL and testbench

Queue controller for the bank system: accepts customer arrivals, keeps the waiting-customer count, and dispatches waiting customers round-robin to the open tellers selected by `tcount`. It drives the up/down pulses and flags consumed by the people counter, seven-segment and wait-time path. It also produces a ticket number and teller index for a "now serving" display.

---
 rtl/bank_pkg.sv | 14 +
 rtl/teller_fsm.sv | 58 +++++
 rtl/bank_queue_scheduler.sv | 134 +++++++++++++
 tb/tb_bank_queue_scheduler.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bank_pkg.sv
// Shared types and sizing for the bank queue scheduler.
package bank_pkg;

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        CALL    = 2'd1,
        SERVING = 2'd2
    } teller_state_t;

    localparam int NUM_TELLERS = 3;
    localparam int QDEPTH      = 15;
    localparam int TICKET_W    = 8;

endpackage

// File: rtl/teller_fsm.sv
// One teller slot: FREE -> CALL on grant, CALL -> SERVING after CALL_CYCLES,
// SERVING -> FREE on the teller's done event.
module teller_fsm
    import bank_pkg::*;
#(
    parameter int CALL_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       grant,
    input  logic       done_ev,
    output logic [1:0] state,
    output logic       busy
);

    localparam int TW = (CALL_CYCLES > 1) ? $clog2(CALL_CYCLES) : 1;
    localparam logic [TW-1:0] LAST = TW'(CALL_CYCLES - 1);

    teller_state_t cur, nxt;
    logic [TW-1:0] timer, timer_nxt;

    // State and CALL timer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur   <= FREE;
            timer <= '0;
        end else begin
            cur   <= nxt;
            timer <= timer_nxt;
        end
    end

    // Next state: done events outside SERVING are deliberately dropped.
    always_comb begin
        nxt       = cur;
        timer_nxt = timer;
        case (cur)
            FREE: begin
                if (grant) begin
                    nxt       = CALL;
                    timer_nxt = '0;
                end
            end
            CALL: begin
                if (timer == LAST) nxt = SERVING;
                else               timer_nxt = timer + 1'b1;
            end
            SERVING: begin
                if (done_ev) nxt = FREE;
            end
            default: nxt = FREE;
        endcase
    end

    assign state = cur;
    assign busy  = (cur != FREE);

endmodule

// File: rtl/bank_queue_scheduler.sv
// Bank queue controller: conditions the buttons, tracks the waiting count and
// tickets, and hands customers round-robin to the open tellers.
module bank_queue_scheduler
    import bank_pkg::*;
#(
    parameter int CALL_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   arrive,
    input  logic [NUM_TELLERS-1:0] teller_done,
    input  logic [1:0]             tcount,
    output logic                   up,
    output logic                   down,
    output logic [3:0]             count,
    output logic                   full_flag,
    output logic                   empty_flag,
    output logic                   drop,
    output logic [NUM_TELLERS-1:0] teller_busy,
    output logic                   call_valid,
    output logic [1:0]             call_teller,
    output logic [TICKET_W-1:0]    call_ticket
);

    logic                   arr_s1, arr_s2, arr_s3, arr_ev;
    logic [NUM_TELLERS-1:0] done_s1, done_s2, done_s3, done_ev;
    logic [TICKET_W-1:0]    next_ticket, serve_ticket;
    logic [1:0]             last_grant;
    logic [NUM_TELLERS-1:0] tel_free, grant_vec;
    logic [1:0]             tel_state [NUM_TELLERS];
    logic                   accept, reject, dispatch, gnt_found;
    logic [1:0]             gnt_idx, idx;
    logic [3:0]             count_nxt;

    // Two-flop synchronizers followed by a registered rising-edge detect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            arr_s1  <= 1'b0;
            arr_s2  <= 1'b0;
            arr_s3  <= 1'b0;
            arr_ev  <= 1'b0;
            done_s1 <= '0;
            done_s2 <= '0;
            done_s3 <= '0;
            done_ev <= '0;
        end else begin
            arr_s1  <= arrive;
            arr_s2  <= arr_s1;
            arr_s3  <= arr_s2;
            arr_ev  <= arr_s2 & ~arr_s3;
            done_s1 <= teller_done;
            done_s2 <= done_s1;
            done_s3 <= done_s2;
            done_ev <= done_s2 & ~done_s3;
        end
    end

    // Round-robin search starting after the last granted teller, open slots only.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = last_grant;
        idx       = '0;
        for (int k = 1; k <= NUM_TELLERS; k++) begin
            idx = 2'((int'(last_grant) + k) % NUM_TELLERS);
            if (!gnt_found && tel_free[idx] && (idx < tcount)) begin
                gnt_found = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

    assign accept    = arr_ev && (count != 4'(QDEPTH));
    assign reject    = arr_ev && (count == 4'(QDEPTH));
    assign dispatch  = (count != 4'd0) && gnt_found;
    assign grant_vec = dispatch ? (NUM_TELLERS'(1) << gnt_idx) : '0;

    // Net count change; an accept and a dispatch in one cycle cancel out.
    always_comb begin
        count_nxt = count;
        case ({accept, dispatch})
            2'b10:   count_nxt = count + 4'd1;
            2'b01:   count_nxt = count - 4'd1;
            default: count_nxt = count;
        endcase
    end

    // Counters, tickets, pulses and the "now serving" registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count        <= '0;
            up           <= 1'b0;
            down         <= 1'b0;
            drop         <= 1'b0;
            full_flag    <= 1'b0;
            empty_flag   <= 1'b1;
            call_valid   <= 1'b0;
            call_teller  <= '0;
            call_ticket  <= '0;
            next_ticket  <= '0;
            serve_ticket <= '0;
            last_grant   <= 2'd2;
        end else begin
            count      <= count_nxt;
            up         <= accept && !dispatch;
            down       <= dispatch && !accept;
            drop       <= reject;
            full_flag  <= (count_nxt == 4'(QDEPTH));
            empty_flag <= (count_nxt == 4'd0);
            call_valid <= dispatch;
            if (accept) next_ticket <= next_ticket + 1'b1;
            if (dispatch) begin
                last_grant   <= gnt_idx;
                call_teller  <= gnt_idx;
                call_ticket  <= serve_ticket;
                serve_ticket <= serve_ticket + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_TELLERS; i++) begin : g_teller
        teller_fsm #(
            .CALL_CYCLES(CALL_CYCLES)
        ) u_teller (
            .clk    (clk),
            .reset  (reset),
            .grant  (grant_vec[i]),
            .done_ev(done_ev[i]),
            .state  (tel_state[i]),
            .busy   (teller_busy[i])
        );
        assign tel_free[i] = (tel_state[i] == FREE);
    end

endmodule

// File: tb/tb_bank_queue_scheduler.sv
// Directed bench for bank_queue_scheduler with hand-computed expectations.
module tb_bank_queue_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       arrive;
    logic [2:0] teller_done;
    logic [1:0] tcount;
    logic       up, down, full_flag, empty_flag, drop, call_valid;
    logic [3:0] count;
    logic [2:0] teller_busy;
    logic [1:0] call_teller;
    logic [7:0] call_ticket;

    int vectors = 0;
    int miscompares = 0;

    logic [1:0] log_t[$];
    logic [7:0] log_k[$];

    bank_queue_scheduler #(.CALL_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .arrive(arrive), .teller_done(teller_done),
        .tcount(tcount), .up(up), .down(down), .count(count),
        .full_flag(full_flag), .empty_flag(empty_flag), .drop(drop),
        .teller_busy(teller_busy), .call_valid(call_valid),
        .call_teller(call_teller), .call_ticket(call_ticket)
    );

    always #5 clk = ~clk;

    // Record every dispatch seen on the opposite clock edge.
    always @(negedge clk) begin
        if (reset === 1'b1 && call_valid === 1'b1) begin
            log_t.push_back(call_teller);
            log_k.push_back(call_ticket);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_arrive();
        arrive = 1'b1;
        tick(1);
        arrive = 1'b0;
    endtask

    task automatic press_done(input int t);
        teller_done[t] = 1'b1;
        tick(1);
        teller_done = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        arrive = 1'b0;
        teller_done = '0;
        tick(2);
        reset = 1'b1;
        tick(1);
        log_t.delete();
        log_k.delete();
    endtask

    task automatic test_reset();
        reset = 1'b0; arrive = 1'b0; teller_done = '0; tcount = 2'd0;
        tick(2);
        vectors++; if (up !== 1'b0) begin miscompares++; $display("FAIL rst_up got %b want 0", up); end
        vectors++; if (down !== 1'b0) begin miscompares++; $display("FAIL rst_down got %b want 0", down); end
        vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL rst_count got %0d want 0", count); end
        vectors++; if (full_flag !== 1'b0) begin miscompares++; $display("FAIL rst_full got %b want 0", full_flag); end
        vectors++; if (empty_flag !== 1'b1) begin miscompares++; $display("FAIL rst_empty got %b want 1", empty_flag); end
        vectors++; if (drop !== 1'b0) begin miscompares++; $display("FAIL rst_drop got %b want 0", drop); end
        vectors++; if (teller_busy !== 3'b000) begin miscompares++; $display("FAIL rst_busy got %b want 000", teller_busy); end
        vectors++; if (call_valid !== 1'b0) begin miscompares++; $display("FAIL rst_cvalid got %b want 0", call_valid); end
        vectors++; if (call_teller !== 2'd0) begin miscompares++; $display("FAIL rst_cteller got %0d want 0", call_teller); end
        vectors++; if (call_ticket !== 8'd0) begin miscompares++; $display("FAIL rst_cticket got %0d want 0", call_ticket); end
        // Mid-run reset: queue one customer with all tellers closed, then reset.
        reset = 1'b1;
        tick(1);
        press_arrive();
        tick(3);
        vectors++; if (up !== 1'b1) begin miscompares++; $display("FAIL pre_rst_up got %b want 1", up); end
        vectors++; if (count !== 4'd1) begin miscompares++; $display("FAIL pre_rst_count got %0d want 1", count); end
        #3 reset = 1'b0;
        #1;
        vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL async_rst_count got %0d want 0", count); end
        vectors++; if (up !== 1'b0) begin miscompares++; $display("FAIL async_rst_up got %b want 0", up); end
        vectors++; if (empty_flag !== 1'b1) begin miscompares++; $display("FAIL async_rst_empty got %b want 1", empty_flag); end
        #2 reset = 1'b1;
        tick(1);
    endtask

    task automatic test_single();
        do_reset();
        tcount = 2'd1;
        press_arrive();
        tick(3);
        vectors++; if (up !== 1'b1) begin miscompares++; $display("FAIL single_up got %b want 1", up); end
        vectors++; if (count !== 4'd1) begin miscompares++; $display("FAIL single_count1 got %0d want 1", count); end
        vectors++; if (down !== 1'b0) begin miscompares++; $display("FAIL single_down0 got %b want 0", down); end
        vectors++; if (empty_flag !== 1'b0) begin miscompares++; $display("FAIL single_empty0 got %b want 0", empty_flag); end
        tick(1);
        vectors++; if (down !== 1'b1) begin miscompares++; $display("FAIL single_down got %b want 1", down); end
        vectors++; if (up !== 1'b0) begin miscompares++; $display("FAIL single_up0 got %b want 0", up); end
        vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL single_count0 got %0d want 0", count); end
        vectors++; if (call_valid !== 1'b1) begin miscompares++; $display("FAIL single_cvalid got %b want 1", call_valid); end
        vectors++; if (call_teller !== 2'd0) begin miscompares++; $display("FAIL single_cteller got %0d want 0", call_teller); end
        vectors++; if (call_ticket !== 8'd0) begin miscompares++; $display("FAIL single_cticket got %0d want 0", call_ticket); end
        vectors++; if (teller_busy !== 3'b001) begin miscompares++; $display("FAIL single_busy got %b want 001", teller_busy); end
        tick(1);
        vectors++; if (call_valid !== 1'b0) begin miscompares++; $display("FAIL single_cvalid_pulse got %b want 0", call_valid); end
        vectors++; if (down !== 1'b0) begin miscompares++; $display("FAIL single_down_pulse got %b want 0", down); end
    endtask

    task automatic test_round_robin();
        do_reset();
        tcount = 2'd3;
        repeat (5) begin
            press_arrive();
            tick(1);
        end
        tick(12);
        vectors++; if (log_t.size() !== 3) begin miscompares++; $display("FAIL rr_dispatches got %0d want 3", log_t.size()); end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (log_t.size() <= i || log_t[i] !== 2'(i) || log_k[i] !== 8'(i)) begin
                miscompares++;
                $display("FAIL rr_grant%0d got teller %0d ticket %0d want teller %0d ticket %0d",
                         i, (log_t.size() > i) ? log_t[i] : 2'd3, (log_k.size() > i) ? log_k[i] : 8'hff, i, i);
            end
        end
        vectors++; if (count !== 4'd2) begin miscompares++; $display("FAIL rr_count got %0d want 2", count); end
        vectors++; if (teller_busy !== 3'b111) begin miscompares++; $display("FAIL rr_busy got %b want 111", teller_busy); end
        press_done(1);
        tick(4);
        vectors++; if (call_valid !== 1'b1) begin miscompares++; $display("FAIL rr_redispatch got %b want 1", call_valid); end
        vectors++; if (call_teller !== 2'd1) begin miscompares++; $display("FAIL rr_t1_teller got %0d want 1", call_teller); end
        vectors++; if (call_ticket !== 8'd3) begin miscompares++; $display("FAIL rr_t1_ticket got %0d want 3", call_ticket); end
        vectors++; if (count !== 4'd1) begin miscompares++; $display("FAIL rr_count_after got %0d want 1", count); end
    endtask

    task automatic test_full_drop();
        do_reset();
        tcount = 2'd0;
        repeat (15) begin
            press_arrive();
            tick(1);
        end
        press_arrive();
        tick(2);
        vectors++; if (count !== 4'd15) begin miscompares++; $display("FAIL full_count got %0d want 15", count); end
        vectors++; if (full_flag !== 1'b1) begin miscompares++; $display("FAIL full_flag got %b want 1", full_flag); end
        vectors++; if (drop !== 1'b0) begin miscompares++; $display("FAIL full_drop_early got %b want 0", drop); end
        tick(1);
        vectors++; if (drop !== 1'b1) begin miscompares++; $display("FAIL full_drop got %b want 1", drop); end
        vectors++; if (up !== 1'b0) begin miscompares++; $display("FAIL full_up got %b want 0", up); end
        vectors++; if (count !== 4'd15) begin miscompares++; $display("FAIL full_count_hold got %0d want 15", count); end
        vectors++; if (dut.next_ticket !== 8'd15) begin miscompares++; $display("FAIL full_next_ticket got %0d want 15", dut.next_ticket); end
        tick(1);
        vectors++; if (drop !== 1'b0) begin miscompares++; $display("FAIL full_drop_pulse got %b want 0", drop); end
        vectors++; if (call_valid !== 1'b0) begin miscompares++; $display("FAIL full_no_dispatch got %b want 0", call_valid); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        tcount = 2'd1;
        press_arrive();
        tick(1);
        press_arrive();
        tick(14);
        vectors++; if (count !== 4'd1) begin miscompares++; $display("FAIL sim_pre_count got %0d want 1", count); end
        teller_done[0] = 1'b1;
        tick(1);
        teller_done = '0;
        arrive = 1'b1;
        tick(1);
        arrive = 1'b0;
        tick(2);
        vectors++; if (teller_busy !== 3'b000) begin miscompares++; $display("FAIL sim_freed got %b want 000", teller_busy); end
        vectors++; if (call_valid !== 1'b0) begin miscompares++; $display("FAIL sim_cvalid_early got %b want 0", call_valid); end
        tick(1);
        vectors++; if (count !== 4'd1) begin miscompares++; $display("FAIL sim_count got %0d want 1", count); end
        vectors++; if (up !== 1'b0) begin miscompares++; $display("FAIL sim_up got %b want 0", up); end
        vectors++; if (down !== 1'b0) begin miscompares++; $display("FAIL sim_down got %b want 0", down); end
        vectors++; if (call_valid !== 1'b1) begin miscompares++; $display("FAIL sim_cvalid got %b want 1", call_valid); end
        vectors++; if (call_ticket !== 8'd1) begin miscompares++; $display("FAIL sim_cticket got %0d want 1", call_ticket); end
        vectors++; if (teller_busy !== 3'b001) begin miscompares++; $display("FAIL sim_busy got %b want 001", teller_busy); end
    endtask

    task automatic test_close_early_done();
        do_reset();
        tcount = 2'd3;
        press_arrive();
        tick(1);
        press_arrive();
        tick(1);
        press_arrive();
        tick(4);
        vectors++; if (call_teller !== 2'd2 || call_valid !== 1'b1) begin miscompares++; $display("FAIL close_grant2 got teller %0d valid %b want 2 1", call_teller, call_valid); end
        press_done(2);
        tick(6);
        vectors++; if (teller_busy !== 3'b111) begin miscompares++; $display("FAIL early_done_ignored got %b want 111", teller_busy); end
        tcount = 2'd2;
        press_done(2);
        tick(3);
        vectors++; if (teller_busy !== 3'b011) begin miscompares++; $display("FAIL close_t2_free got %b want 011", teller_busy); end
        press_arrive();
        tick(8);
        vectors++; if (count !== 4'd1) begin miscompares++; $display("FAIL close_count got %0d want 1", count); end
        vectors++; if (teller_busy !== 3'b011) begin miscompares++; $display("FAIL close_no_regrant got %b want 011", teller_busy); end
        vectors++; if (log_t.size() !== 3) begin miscompares++; $display("FAIL close_dispatches got %0d want 3", log_t.size()); end
        press_done(0);
        tick(4);
        vectors++; if (call_valid !== 1'b1 || call_teller !== 2'd0) begin miscompares++; $display("FAIL close_t0_grant got teller %0d valid %b want 0 1", call_teller, call_valid); end
        vectors++; if (call_ticket !== 8'd3) begin miscompares++; $display("FAIL close_t0_ticket got %0d want 3", call_ticket); end
        vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL close_count0 got %0d want 0", count); end
    endtask

    initial begin
        reset = 1'b0;
        arrive = 1'b0;
        teller_done = '0;
        tcount = 2'd0;
        test_reset();
        test_single();
        test_round_robin();
        test_full_drop();
        test_simultaneous();
        test_close_early_done();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
